// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; the memory is the slave.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, request/ack fetch, redirect on taken
// branch/jump, and a sticky error on misaligned redirect targets.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  imem,
    input  logic                stall,
    input  logic                pc_src,
    input  logic [XLEN-1:0]     pc_target,
    output logic [31:0]         instr,
    output logic [XLEN-1:0]     instr_pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic [6:0]          opcode,
    output logic                instr_valid,
    output logic                misalign_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        VALID,
        ERROR
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_instr_valid;
    logic            r_misalign_err;

    logic            w_req;
    logic            w_fetch_done;
    logic            w_advance;
    logic            w_misalign;
    logic [XLEN-1:0] w_next_pc;

    assign w_next_pc = pc_src ? pc_target : r_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_fetch_done = 1'b0;
        w_advance    = 1'b0;
        w_misalign   = 1'b0;
        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (imem.imem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_next = VALID;
                end
            end
            VALID: begin
                if (!stall) begin
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_misalign   = 1'b1;
                        w_state_next = ERROR;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = FETCH;
                    end
                end
            end
            ERROR: begin
                w_state_next = ERROR;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_instr        <= NOP;
            r_instr_pc     <= RESET_PC;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            if (w_fetch_done) begin
                r_instr       <= imem.imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end
            if (w_advance) begin
                r_pc          <= w_next_pc;
                r_instr_valid <= 1'b0;
            end
            // PC is left at the faulting instruction so imem_addr stays stable in ERROR
            if (w_misalign) begin
                r_misalign_err <= 1'b1;
                r_instr_valid  <= 1'b0;
            end
        end
    end

    // rst gates the request so no fetch is issued while reset is asserted
    assign imem.imem_req  = w_req && !rst;
    assign imem.imem_addr = r_pc;

    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign pc_plus4     = r_instr_pc + XLEN'(4);
    assign opcode       = r_instr_valid ? r_instr[6:0] : 7'b000_0000;
    assign instr_valid  = r_instr_valid;
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: two instances (RESET_PC 0 and 0xFFFFFFFC)
// share stimulus and are compared each cycle against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack;
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_target;

    logic [31:0] o_instr    [2];
    logic [31:0] o_instr_pc [2];
    logic [31:0] o_pc_plus4 [2];
    logic [6:0]  o_opcode   [2];
    logic        o_valid    [2];
    logic        o_err      [2];
    logic        o_req      [2];
    logic [31:0] o_addr     [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    // Reference model: what the stage currently holds, in plain terms
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_ipc   [2];
    logic        m_valid [2];
    logic        m_err   [2];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) if0 ();
    instr_fetch_unit_if #(.XLEN(32)) if1 ();

    assign if0.imem_ack = ack;
    assign if1.imem_ack = ack;
    assign o_req[0]  = if0.imem_req;
    assign o_req[1]  = if1.imem_req;
    assign o_addr[0] = if0.imem_addr;
    assign o_addr[1] = if1.imem_addr;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .imem         (if0.master),
        .stall        (stall),
        .pc_src       (pc_src),
        .pc_target    (pc_target),
        .instr        (o_instr[0]),
        .instr_pc     (o_instr_pc[0]),
        .pc_plus4     (o_pc_plus4[0]),
        .opcode       (o_opcode[0]),
        .instr_valid  (o_valid[0]),
        .misalign_err (o_err[0])
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .imem         (if1.master),
        .stall        (stall),
        .pc_src       (pc_src),
        .pc_target    (pc_target),
        .instr        (o_instr[1]),
        .instr_pc     (o_instr_pc[1]),
        .pc_plus4     (o_pc_plus4[1]),
        .opcode       (o_opcode[1]),
        .instr_valid  (o_valid[1]),
        .misalign_err (o_err[1])
    );

    function automatic logic [31:0] reset_pc(int k);
        return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]    = reset_pc(k);
            m_instr[k] = 32'h0000_0013;
            m_ipc[k]   = reset_pc(k);
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
        end
    endtask

    task automatic check_all();
        logic        exp_req;
        logic [31:0] exp_op;
        for (int k = 0; k < 2; k++) begin
            exp_req = !rst && !m_valid[k] && !m_err[k];
            exp_op  = m_valid[k] ? {25'd0, m_instr[k][6:0]} : 32'd0;
            check($sformatf("c%0d d%0d imem_req", cycle, k), {31'd0, o_req[k]}, {31'd0, exp_req});
            check($sformatf("c%0d d%0d imem_addr", cycle, k), o_addr[k], m_pc[k]);
            check($sformatf("c%0d d%0d instr_valid", cycle, k), {31'd0, o_valid[k]}, {31'd0, m_valid[k]});
            check($sformatf("c%0d d%0d misalign_err", cycle, k), {31'd0, o_err[k]}, {31'd0, m_err[k]});
            check($sformatf("c%0d d%0d opcode", cycle, k), {25'd0, o_opcode[k]}, exp_op);
            check($sformatf("c%0d d%0d instr", cycle, k), o_instr[k], m_instr[k]);
            check($sformatf("c%0d d%0d instr_pc", cycle, k), o_instr_pc[k], m_ipc[k]);
            check($sformatf("c%0d d%0d pc_plus4", cycle, k), o_pc_plus4[k], m_ipc[k] + 32'd4);
        end
    endtask

    // Applies the stage's rules for one clock edge given the inputs just sampled
    task automatic model_edge();
        logic [31:0] nxt;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (m_err[k]) begin
                // stuck until reset
            end else if (!m_valid[k]) begin
                if (ack) begin
                    m_instr[k] = mem_word(m_pc[k]);
                    m_ipc[k]   = m_pc[k];
                    m_valid[k] = 1'b1;
                end
            end else if (!stall) begin
                nxt = pc_src ? pc_target : m_pc[k] + 32'd4;
                m_valid[k] = 1'b0;
                if (nxt[1:0] != 2'b00) m_err[k] = 1'b1;
                else                   m_pc[k]  = nxt;
            end
        end
    endtask

    task automatic step(input logic r, input logic a, input logic s,
                        input logic src, input logic [31:0] tgt);
        rst            = r;
        ack            = a;
        stall          = s;
        pc_src         = src;
        pc_target      = tgt;
        if0.imem_rdata = mem_word(m_pc[0]);
        if1.imem_rdata = mem_word(m_pc[1]);
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
    endtask

    initial begin
        logic        r, a, s, src;
        logic [31:0] tgt;

        rst            = 1'b1;
        ack            = 1'b1;
        stall          = 1'b0;
        pc_src         = 1'b0;
        pc_target      = '0;
        if0.imem_rdata = '0;
        if1.imem_rdata = '0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset with ack high, then zero-wait sequential fetch (dut1 wraps to 0)
        repeat (2)  step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Three wait states, then a 4-cycle stall with a redirect pending
        repeat (3)  step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4)  step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
        repeat (4)  step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Misaligned redirect, error hold, then reset with ack in the same cycle
        repeat (4)  step(1'b0, 1'b1, 1'b0, 1'b1, 32'h42);
        repeat (3)  step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        repeat (3000) begin
            r   = ($urandom_range(0, 59) == 0);
            a   = $urandom_range(0, 1) == 1;
            s   = ($urandom_range(0, 9) < 3);
            src = ($urandom_range(0, 3) == 0);
            tgt = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 29) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            step(r, a, s, src, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
